// File: rtl/ibex_instr_req_ctrl_if.sv
// Instruction-bus handshake between the fetch request controller and memory.
// The controller side drives the request and address; memory answers with
// grant and, later and in order, the response word.
interface ibex_instr_req_ctrl_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/ibex_instr_req_ctrl.sv
// Instruction fetch request controller.
// Issues word-aligned fetch requests on the instruction bus, holds a request
// stable until it is granted, tracks up to NUM_REQS outstanding requests in an
// in-order queue and drops responses that belong to fetches made stale by a
// branch. Live responses are forwarded to the fetch FIFO with zero latency.
module ibex_instr_req_ctrl #(
    parameter int NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,

    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,

    output logic                busy_o,

    ibex_instr_req_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(NUM_REQS + 1);

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_e;

    state_e              state_q;
    logic [31:0]         held_addr_q;   // address of the request waiting for grant
    logic                held_stale_q;  // a branch arrived while the request was held
    logic [31:0]         fetch_addr_q;  // next address to request from IDLE
    logic [31:0]         fetch_addr_d;
    logic [CNT_W-1:0]    count_q;       // outstanding (granted, unanswered) requests
    logic [CNT_W-1:0]    count_d;
    logic [CNT_W-1:0]    count_after_pop;
    logic [NUM_REQS-1:0] discard_q;     // bit 0 belongs to the oldest entry
    logic [NUM_REQS-1:0] discard_d;

    logic [31:0]         branch_target;
    logic                q_empty;
    logic                q_full;
    int                  live_cnt;
    int                  fifo_busy_cnt;
    logic                fifo_room;
    logic                idle_req;
    logic                req_raw;
    logic [31:0]         addr_out;
    logic                accept;
    logic                pop;
    logic                push_discard;

    assign branch_target = {branch_addr_i[31:2], 2'b00};
    assign q_empty       = (count_q == '0);
    assign q_full        = (int'(count_q) >= NUM_REQS);

    // Count queue entries whose response will still be forwarded.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        live_cnt = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (i < int'(count_q) && !discard_q[i]) begin
                live_cnt = live_cnt + 1;
            end
        end
    end

    // Count occupied upper FIFO entries.
    always_comb begin
        fifo_busy_cnt = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (fifo_busy_i[i]) begin
                fifo_busy_cnt = fifo_busy_cnt + 1;
            end
        end
    end

    // A branch flushes the FIFO, so its current fill no longer limits requests.
    assign fifo_room = (live_cnt + fifo_busy_cnt) < NUM_REQS;
    assign idle_req  = req_i & ~q_full & (branch_i | fifo_room);

    // Select request and address: new fetch from IDLE, held request otherwise.
    always_comb begin
        req_raw  = 1'b0;
        addr_out = fetch_addr_q;
        unique case (state_q)
            IDLE: begin
                req_raw  = idle_req;
                addr_out = branch_i ? branch_target : fetch_addr_q;
            end
            WAIT_GNT: begin
                req_raw  = 1'b1;
                addr_out = held_addr_q;
            end
        endcase
    end

    // The request depends combinationally on req_i, so it is also forced low
    // while reset is asserted.
    assign bus.req  = rst_ni & req_raw;
    assign bus.addr = addr_out;

    assign accept = bus.req & bus.gnt;
    assign pop    = bus.rvalid & ~q_empty;

    // A held request granted after (or together with) a branch fetches a stale
    // address. A request issued from IDLE alongside a branch is the target itself.
    assign push_discard = (state_q == WAIT_GNT) & (held_stale_q | branch_i);

    // Next queue contents: pop oldest, mark survivors on branch, append grant.
    always_comb begin
        discard_d       = discard_q;
        count_after_pop = count_q;
        if (pop) begin
            discard_d       = discard_q >> 1;
            count_after_pop = count_q - CNT_W'(1);
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (i >= int'(count_after_pop)) begin
                discard_d[i] = 1'b0;
            end else if (branch_i) begin
                discard_d[i] = 1'b1;
            end
            if (accept && i == int'(count_after_pop)) begin
                discard_d[i] = push_discard;
            end
        end
        count_d = count_after_pop + CNT_W'(accept);
    end

    // Next fetch address: branch target (skipping it if granted now), or +4
    // after a grant of the address it holds.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            if (state_q == IDLE && accept) begin
                fetch_addr_d = branch_target + 32'd4;
            end else begin
                fetch_addr_d = branch_target;
            end
        end else if (accept && !(state_q == WAIT_GNT && held_stale_q)) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end
    end

    // Request FSM: hold an ungranted request and remember if a branch made it stale.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            held_addr_q  <= '0;
            held_stale_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update from the same pre-edge values.
            unique case (state_q)
                IDLE: begin
                    if (bus.req && !bus.gnt) begin
                        state_q      <= WAIT_GNT;
                        held_addr_q  <= addr_out;
                        held_stale_q <= 1'b0;
                    end
                end
                WAIT_GNT: begin
                    if (bus.gnt) begin
                        state_q      <= IDLE;
                        held_stale_q <= 1'b0;
                    end else if (branch_i) begin
                        held_stale_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Outstanding queue and fetch address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the discard bits are reset as well; the queue is a few flops,
            // not a RAM, and reset must drop every outstanding response at once.
            count_q      <= '0;
            discard_q    <= '0;
            fetch_addr_q <= '0;
        end else begin
            count_q      <= count_d;
            discard_q    <= discard_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = branch_addr_i;
    assign fifo_valid_o = bus.rvalid & ~q_empty & ~discard_q[0];
    assign fifo_rdata_o = bus.rdata;
    assign fifo_err_o   = bus.err;

    assign busy_o = (state_q == WAIT_GNT) | ~q_empty;

    // A response must always belong to an outstanding request.
    rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) bus.rvalid |-> !q_empty
    );

    // Requests are only raised with room in the queue, so a grant never overflows it.
    no_grant_when_full: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (bus.req && bus.gnt) |-> !q_full
    );

endmodule
